// File: rtl/ssd_pkg.sv
// ssd_pkg: shared constants and types for the seven-segment driver.
//   NUM_DIGITS / VALUE_W  - display width and binary input width
//   conv_state_e          - binary-to-BCD converter FSM states
//   SEG_*                 - active-low segment patterns {g,f,e,d,c,b,a}
//   dd_adjust()           - add-3 correction step of double dabble
package ssd_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int VALUE_W    = 13;
    localparam int BCD_W      = 4 * NUM_DIGITS;
    localparam int DIG_W      = $clog2(NUM_DIGITS);
    localparam int ITER_W     = 4;

    // One shift per input bit, counter runs 0..VALUE_W-1.
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(VALUE_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } conv_state_e;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Any nibble >= 5 gets +3 so the following left shift carries
    // correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] sr);
        logic [BCD_W-1:0] r;
        r = sr;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/seven_seg_driver_if.sv
// seven_seg_driver_if: CPU-side value input plus display/status outputs.
//   value   - binary quantity to display (from CPU)
//   anode   - active-low digit enables, bit 0 = least-significant digit
//   cathode - active-low segments {g,f,e,d,c,b,a}
//   bcd     - committed BCD digits, digit 3 in [15:12]
//   busy    - conversion in progress
// master: the side that supplies value; slave: the driver.
interface seven_seg_driver_if;
    import ssd_pkg::*;

    logic [VALUE_W-1:0]    value;
    logic [NUM_DIGITS-1:0] anode;
    logic [6:0]            cathode;
    logic [BCD_W-1:0]      bcd;
    logic                  busy;

    modport master (
        output value,
        input  anode, cathode, bcd, busy
    );

    modport slave (
        input  value,
        output anode, cathode, bcd, busy
    );

endinterface

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: combinational BCD nibble to active-low 7-segment decoder.
//   digit - BCD nibble (codes above 9 decode to all-off)
//   blank - force all segments off
//   seg   - active-low segments {g,f,e,d,c,b,a}
module bcd_to_seg
    import ssd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seven_seg_driver.sv
// seven_seg_driver: converts a 13-bit binary value to BCD with a
// sequential double-dabble engine and multiplexes the four digits onto a
// common-anode display.
//   clk - clock, all state on rising edge
//   rst - asynchronous active-high reset
//   io  - slave side of seven_seg_driver_if (value in; anode, cathode,
//         bcd, busy out)
// Parameters: REFRESH_DIV = cycles per digit, BLANK_LZ = leading-zero
// blanking enable.
module seven_seg_driver
    import ssd_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LZ    = 1
) (
    input  logic               clk,
    input  logic               rst,
    seven_seg_driver_if.slave  io
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    // ---------------- converter ----------------
    conv_state_e        state_q, state_d;
    logic [VALUE_W-1:0] val_q;
    logic [BCD_W-1:0]   sr_q, sr_adj, bcd_q;
    logic [ITER_W-1:0]  iter_q;
    logic               in_bit;
    logic               busy_c;
    logic               val_changed;

    assign val_changed = (io.value != val_q);
    assign sr_adj      = dd_adjust(sr_q);
    // MSB first: iteration 0 consumes bit VALUE_W-1.
    assign in_bit      = val_q[ITER_LAST - iter_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (val_changed)        state_d = CONVERT;
            CONVERT: if (iter_q == ITER_LAST) state_d = COMMIT;
            COMMIT:                           state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_c = (state_q != IDLE);
    end

    // value is sampled only in IDLE, so changes mid-conversion are picked
    // up by the next IDLE comparison rather than corrupting this one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q  <= '0;
            sr_q   <= '0;
            iter_q <= '0;
            bcd_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (val_changed) begin
                        val_q  <= io.value;
                        sr_q   <= '0;
                        iter_q <= '0;
                    end
                end
                CONVERT: begin
                    sr_q   <= {sr_adj[BCD_W-2:0], in_bit};
                    iter_q <= iter_q + 4'd1;
                end
                COMMIT: bcd_q <= sr_q;
                default: ;
            endcase
        end
    end

    // ---------------- display scan ----------------
    logic [CNT_W-1:0]      ref_cnt_q;
    logic [DIG_W-1:0]      dig_idx_q;
    logic [3:0]            cur_nibble;
    logic                  cur_blank;
    logic [6:0]            seg_c;
    logic [NUM_DIGITS-1:0] anode_q;
    logic [6:0]            cathode_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt_q <= '0;
            dig_idx_q <= '0;
        end else if (ref_cnt_q == CNT_LAST) begin
            ref_cnt_q <= '0;
            dig_idx_q <= dig_idx_q + 1'b1;
        end else begin
            ref_cnt_q <= ref_cnt_q + 1'b1;
        end
    end

    assign cur_nibble = bcd_q[{dig_idx_q, 2'b00} +: 4];
    // Blank when this digit and every digit above it are zero; digit 0
    // always shows so a value of 0 reads "0".
    assign cur_blank  = (BLANK_LZ != 0) && (dig_idx_q != '0) &&
                        ((bcd_q >> {dig_idx_q, 2'b00}) == '0);

    bcd_to_seg u_dec (
        .digit (cur_nibble),
        .blank (cur_blank),
        .seg   (seg_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anode_q   <= '1;
            cathode_q <= SEG_BLANK;
        end else begin
            anode_q   <= ~(NUM_DIGITS'(1) << dig_idx_q);
            cathode_q <= seg_c;
        end
    end

    assign io.anode   = anode_q;
    assign io.cathode = cathode_q;
    assign io.bcd     = bcd_q;
    assign io.busy    = busy_c;

endmodule

// File: tb/tb_seven_seg_driver.sv
// tb_seven_seg_driver: randomized and directed checks of seven_seg_driver
// against a decimal-arithmetic reference model. Two instances share
// stimulus: one with leading-zero blanking, one without.
module tb_seven_seg_driver;

    localparam int RDIV = 4;

    logic clk = 1'b0;
    logic rst;

    seven_seg_driver_if io_lz ();
    seven_seg_driver_if io_nb ();

    seven_seg_driver #(.REFRESH_DIV(RDIV), .BLANK_LZ(1)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io_lz)
    );

    seven_seg_driver #(.REFRESH_DIV(RDIV), .BLANK_LZ(0)) dut_nb (
        .clk (clk),
        .rst (rst),
        .io  (io_nb)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int model_val = 0;   // value whose BCD is currently committed

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
                                 7'b0110000, 7'b0011001, 7'b0010010,
                                 7'b0000010, 7'b1111000, 7'b0000000,
                                 7'b0010000};
    int pow10 [4] = '{1, 10, 100, 1000};

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10),
                4'((v / 10) % 10),   4'(v % 10)};
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int k, input bit lz);
        if (lz && k > 0 && v < pow10[k]) return 7'b1111111;
        return seg_tab[(v / pow10[k]) % 10];
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_value(input int v);
        io_lz.value = 13'(v);
        io_nb.value = 13'(v);
    endtask

    // Drive v and watch 15 edges: busy high for 14, bcd flips on edge 15.
    task automatic convert_check(input string name, input int v);
        int prev;
        logic exp_busy;
        logic [15:0] exp_bcd;
        prev = model_val;
        set_value(v);
        for (int e = 1; e <= 15; e++) begin
            step(1);
            exp_busy = (v != prev) && (e <= 14);
            exp_bcd  = (v != prev && e == 15) ? to_bcd(v) : to_bcd(prev);
            n_checks++;
            if (io_lz.busy !== exp_busy) begin
                n_fail++;
                $display("FAIL %s busy edge %0d: got %b want %b", name, e, io_lz.busy, exp_busy);
            end
            n_checks++;
            if (io_lz.bcd !== exp_bcd || io_nb.bcd !== exp_bcd) begin
                n_fail++;
                $display("FAIL %s bcd edge %0d: got %h/%h want %h", name, e, io_lz.bcd, io_nb.bcd, exp_bcd);
            end
        end
        model_val = v;
    endtask

    // Scan the display and check each enabled digit's pattern.
    task automatic scan_check(input string name, input int v);
        logic [3:0] seen_lz, seen_nb;
        int zl, zn, kl, kn;
        seen_lz = '0;
        seen_nb = '0;
        for (int c = 0; c < 4 * RDIV + 2; c++) begin
            step(1);
            zl = 0; zn = 0; kl = 0; kn = 0;
            for (int b = 0; b < 4; b++) begin
                if (io_lz.anode[b] == 1'b0) begin zl++; kl = b; end
                if (io_nb.anode[b] == 1'b0) begin zn++; kn = b; end
            end
            n_checks++;
            if (zl != 1 || zn != 1) begin
                n_fail++;
                $display("FAIL %s anode onehot: got %b/%b want one low bit", name, io_lz.anode, io_nb.anode);
            end else begin
                seen_lz[kl] = 1'b1;
                seen_nb[kn] = 1'b1;
                n_checks++;
                if (io_lz.cathode !== exp_seg(v, kl, 1'b1)) begin
                    n_fail++;
                    $display("FAIL %s cathode lz digit %0d: got %b want %b", name, kl, io_lz.cathode, exp_seg(v, kl, 1'b1));
                end
                n_checks++;
                if (io_nb.cathode !== exp_seg(v, kn, 1'b0)) begin
                    n_fail++;
                    $display("FAIL %s cathode nb digit %0d: got %b want %b", name, kn, io_nb.cathode, exp_seg(v, kn, 1'b0));
                end
            end
        end
        n_checks++;
        if (seen_lz !== 4'hF || seen_nb !== 4'hF) begin
            n_fail++;
            $display("FAIL %s scan coverage: got %b/%b want 1111", name, seen_lz, seen_nb);
        end
    endtask

    task automatic check_in_reset(input string name);
        n_checks++;
        if (io_lz.anode !== 4'hF || io_lz.cathode !== 7'h7F ||
            io_lz.bcd !== 16'h0 || io_lz.busy !== 1'b0 || io_nb.bcd !== 16'h0) begin
            n_fail++;
            $display("FAIL %s: got anode %b cathode %b bcd %h busy %b want 1111 1111111 0000 0",
                     name, io_lz.anode, io_lz.cathode, io_lz.bcd, io_lz.busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_value(0);
        step(2);
        check_in_reset("reset_hold");
        rst = 1'b0;
        step(1);
        n_checks++;
        if (io_lz.anode !== 4'b1110 || io_lz.cathode !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_release: got anode %b cathode %b want 1110 1000000", io_lz.anode, io_lz.cathode);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (io_lz.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle busy: got %b want 0", io_lz.busy);
            end
            step(1);
        end
        model_val = 0;
    endtask

    task automatic test_main();
        convert_check("conv_1234", 1234);
        scan_check("scan_1234", 1234);
    endtask

    task automatic test_blanking();
        convert_check("conv_7", 7);
        scan_check("scan_7", 7);
    endtask

    task automatic test_max();
        convert_check("conv_8191", 8191);
        scan_check("scan_8191", 8191);
    endtask

    // Change value 5 edges into a conversion; first commit keeps the old
    // value, the new one lands 15 edges after that.
    task automatic test_back_to_back();
        int prev;
        logic exp_busy;
        logic [15:0] exp_bcd;
        prev = model_val;
        set_value(100);
        for (int e = 1; e <= 34; e++) begin
            step(1);
            if (e == 5) set_value(200);
            exp_bcd  = (e < 15) ? to_bcd(prev) : (e < 30) ? to_bcd(100) : to_bcd(200);
            exp_busy = (e <= 14) || (e >= 16 && e <= 29);
            n_checks++;
            if (io_lz.bcd !== exp_bcd) begin
                n_fail++;
                $display("FAIL b2b bcd edge %0d: got %h want %h", e, io_lz.bcd, exp_bcd);
            end
            n_checks++;
            if (io_lz.busy !== exp_busy) begin
                n_fail++;
                $display("FAIL b2b busy edge %0d: got %b want %b", e, io_lz.busy, exp_busy);
            end
        end
        model_val = 200;
    endtask

    task automatic test_reset_mid();
        set_value(4321);
        step(7);
        rst = 1'b1;
        #1;
        check_in_reset("rst_mid_immediate");
        step(1);
        check_in_reset("rst_mid_hold");
        rst = 1'b0;
        model_val = 0;
        convert_check("rst_mid_reconv", 4321);
    endtask

    task automatic test_random();
        int v;
        for (int i = 0; i < 20; i++) begin
            v = int'($urandom_range(8191, 0));
            if ($urandom_range(3, 0) == 0) v = model_val;
            convert_check("rand_conv", v);
            if (i % 5 == 0) scan_check("rand_scan", v);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_value(0);
        test_reset();
        test_main();
        test_blanking();
        test_max();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
